// File: rtl/brc_pkg.sv
// Branch comparator shared definitions.
// Holds the RISC-V branch funct3 encodings and decode helpers.
package brc_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  // funct3 bit that selects an unsigned compare
  localparam int F3_UNSIGNED_BIT = 1;

  // 010 and 011 are not branch encodings
  function automatic logic is_illegal_f3(
    input logic [2:0] f3
  );
    return (f3[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/brc_chunk_cmp.sv
// One segment of the stage-1 partial compare.
// Ports: a_i/b_i segment operands; eq_o a==b; ltu_o a<b unsigned.
module brc_chunk_cmp
  import brc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         eq_o,
  output logic         ltu_o
);

  assign eq_o  = (a_i == b_i);
  assign ltu_o = (a_i < b_i);

endmodule

// File: rtl/brc_pipe.sv
// Two-stage pipelined branch comparator with valid/ready and flush.
// Ports: i_clk, i_reset (async high), i_flush;
//   in:  i_valid/o_ready, i_rs1_data, i_rs2_data, i_funct3, i_tag;
//   out: o_valid/i_ready, o_br_less, o_br_equal, o_taken,
//        o_illegal, o_tag.
// Define BRC_PERF_EN to add o_eval_cnt / o_taken_cnt.
module brc_pipe
  import brc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAG_W = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic [2:0]       i_funct3,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_br_less,
  output logic             o_br_equal,
  output logic             o_taken,
  output logic             o_illegal,
  output logic [TAG_W-1:0] o_tag
`ifdef BRC_PERF_EN
  ,
  output logic [31:0]      o_eval_cnt,
  output logic [31:0]      o_taken_cnt
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;

  // handshake / advance
  logic s2_adv;
  logic s1_adv;
  logic in_fire;
  logic s2_load;

  // stage 1 state
  logic              s1_v_q, s1_v_d;
  logic [NCHUNK-1:0] eq_q,   eq_d;
  logic [NCHUNK-1:0] ltu_q,  ltu_d;
  logic              sa_q,   sa_d;
  logic              sb_q,   sb_d;
  logic [2:0]        f3_q,   f3_d;
  logic [TAG_W-1:0]  tag1_q, tag1_d;

  // stage 2 state
  logic              s2_v_q,  s2_v_d;
  logic              less_q,  less_d;
  logic              equal_q, equal_d;
  logic              taken_q, taken_d;
  logic              ill_q,   ill_d;
  logic [TAG_W-1:0]  tag2_q,  tag2_d;

  // stage 2 combinational resolve
  logic              equal_c;
  logic              ult_c;
  logic              slt_c;
  logic              less_c;
  logic              ill_c;
  logic              taken_c;

  // chunk compares
  logic [NCHUNK-1:0] eq_c;
  logic [NCHUNK-1:0] ltu_c;

  for (genvar k = 0; k < NCHUNK; k++) begin : g_cmp
    brc_chunk_cmp #(
      .W (CHUNK)
    ) u_cmp (
      .a_i   (i_rs1_data[k*CHUNK +: CHUNK]),
      .b_i   (i_rs2_data[k*CHUNK +: CHUNK]),
      .eq_o  (eq_c[k]),
      .ltu_o (ltu_c[k])
    );
  end

  assign s2_adv  = !s2_v_q | i_ready;
  assign s1_adv  = !s1_v_q | s2_adv;
  assign in_fire = i_valid & s1_adv;
  assign s2_load = s1_adv & s1_v_q;

  // stage 1 next state
  always_comb begin
    eq_d   = eq_q;
    ltu_d  = ltu_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    f3_d   = f3_q;
    tag1_d = tag1_q;
    if (in_fire) begin
      eq_d   = eq_c;
      ltu_d  = ltu_c;
      sa_d   = i_rs1_data[WIDTH-1];
      sb_d   = i_rs2_data[WIDTH-1];
      f3_d   = i_funct3;
      tag1_d = i_tag;
    end
  end

  // a flushed input may still write data; only valid is killed
  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    if (s1_adv) begin
      s1_v_d = in_fire;
    end
    if (s2_adv) begin
      s2_v_d = s1_v_q;
    end
    if (i_flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end
  end

  // highest differing chunk decides the unsigned order
  always_comb begin
    ult_c = 1'b0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (!eq_q[k]) begin
        ult_c = ltu_q[k];
      end
    end
  end

  assign equal_c = &eq_q;
  assign slt_c   = (sa_q ^ sb_q) ? sa_q : ult_c;
  assign less_c  = f3_q[F3_UNSIGNED_BIT] ? ult_c : slt_c;
  assign ill_c   = is_illegal_f3(f3_q);

  // funct3[0] inverts the base condition
  always_comb begin
    taken_c = 1'b0;
    unique case (1'b1)
      ill_c:
        taken_c = 1'b0;
      (f3_q[2:1] == 2'b00):
        taken_c = equal_c ^ f3_q[0];
      f3_q[2]:
        taken_c = less_c ^ f3_q[0];
      default:
        taken_c = 1'b0;
    endcase
  end

  // stage 2 next state; holds under backpressure
  always_comb begin
    less_d  = less_q;
    equal_d = equal_q;
    taken_d = taken_q;
    ill_d   = ill_q;
    tag2_d  = tag2_q;
    if (s2_load) begin
      less_d  = less_c;
      equal_d = equal_c;
      taken_d = taken_c;
      ill_d   = ill_c;
      tag2_d  = tag1_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_v_q  <= 1'b0;
      eq_q    <= '0;
      ltu_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      f3_q    <= '0;
      tag1_q  <= '0;
      s2_v_q  <= 1'b0;
      less_q  <= 1'b0;
      equal_q <= 1'b0;
      taken_q <= 1'b0;
      ill_q   <= 1'b0;
      tag2_q  <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      eq_q    <= eq_d;
      ltu_q   <= ltu_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      f3_q    <= f3_d;
      tag1_q  <= tag1_d;
      s2_v_q  <= s2_v_d;
      less_q  <= less_d;
      equal_q <= equal_d;
      taken_q <= taken_d;
      ill_q   <= ill_d;
      tag2_q  <= tag2_d;
    end
  end

  assign o_ready    = s1_adv;
  assign o_valid    = s2_v_q;
  assign o_br_less  = less_q;
  assign o_br_equal = equal_q;
  assign o_taken    = taken_q;
  assign o_illegal  = ill_q;
  assign o_tag      = tag2_q;

`ifdef BRC_PERF_EN
  logic        out_fire;
  logic [31:0] eval_q, eval_d;
  logic [31:0] tcnt_q, tcnt_d;

  // a result delivered in a flush cycle still counts
  assign out_fire = s2_v_q & i_ready;

  always_comb begin
    eval_d = eval_q;
    tcnt_d = tcnt_q;
    if (out_fire) begin
      eval_d = eval_q + 32'd1;
      if (taken_q) begin
        tcnt_d = tcnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      eval_q <= '0;
      tcnt_q <= '0;
    end else begin
      eval_q <= eval_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign o_eval_cnt  = eval_q;
  assign o_taken_cnt = tcnt_q;
`endif

endmodule

// File: tb/tb_brc_pipe.sv
// Scoreboard bench for brc_pipe.
// Directed vectors; monitor pops expected results on output handshakes.
module tb_brc_pipe;
  import brc_pkg::*;

  localparam int W  = 32;
  localparam int TW = 6;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_rs1_data;
  logic [W-1:0]  i_rs2_data;
  logic [2:0]    i_funct3;
  logic [TW-1:0] i_tag;
  logic          o_valid;
  logic          i_ready;
  logic          o_br_less;
  logic          o_br_equal;
  logic          o_taken;
  logic          o_illegal;
  logic [TW-1:0] o_tag;
`ifdef BRC_PERF_EN
  logic [31:0]   o_eval_cnt;
  logic [31:0]   o_taken_cnt;
`endif

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        l;
    logic        e;
    logic        t;
    logic        il;
  } vec_t;

  typedef struct {
    logic [9:0] res;
    bit         lat;
    int         issue;
  } exp_t;

  exp_t       q[$];
  vec_t       vt[12];
  int         pl[10] = '{0, 1, 2, 3, 4, 6, 9, 10, 11, 1};
  logic [9:0] cur_res;
  bit         cur_lat;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;

  brc_pipe #(
    .WIDTH (W),
    .CHUNK (8),
    .TAG_W (TW)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_rs1_data  (i_rs1_data),
    .i_rs2_data  (i_rs2_data),
    .i_funct3    (i_funct3),
    .i_tag       (i_tag),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_br_less   (o_br_less),
    .o_br_equal  (o_br_equal),
    .o_taken     (o_taken),
    .o_illegal   (o_illegal),
    .o_tag       (o_tag)
`ifdef BRC_PERF_EN
    ,
    .o_eval_cnt  (o_eval_cnt),
    .o_taken_cnt (o_taken_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor + scoreboard, sampled at the falling edge
  always @(negedge i_clk) begin : sb
    exp_t e;
    if (o_valid) begin
      chk("have_expect", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        chk("result",
            {o_br_less, o_br_equal, o_taken, o_illegal, o_tag},
            q[0].res);
        if (i_ready) begin
          e = q.pop_front();
          if (e.lat) begin
            chk("latency", 64'(cyc - e.issue), 64'd2);
          end
        end
      end
    end
    if (i_flush) begin
      q.delete();
    end else if (i_valid && o_ready && !i_reset) begin
      q.push_back('{cur_res, cur_lat, cyc});
    end
  end

  task automatic present(
    input vec_t          v,
    input logic [TW-1:0] tag,
    input bit            lat
  );
    i_valid    = 1'b1;
    i_rs1_data = v.a;
    i_rs2_data = v.b;
    i_funct3   = v.f3;
    i_tag      = tag;
    cur_res    = {v.l, v.e, v.t, v.il, tag};
    cur_lat    = lat;
  endtask

  task automatic send(
    input vec_t          v,
    input logic [TW-1:0] tag,
    input bit            lat
  );
    bit acc;
    acc = 1'b0;
    present(v, tag, lat);
    for (int n = 0; n < 64; n++) begin
      @(negedge i_clk);
      if (o_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 64; n++) begin
      if (q.size() == 0) break;
      @(posedge i_clk);
      #1;
    end
    repeat (2) @(posedge i_clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{BLTU, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{BLT,  32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{BGE,  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{BLTU, 32'h0100_00FF, 32'h00FF_FF00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{BLTU, 32'h00FF_FF00, 32'h0100_00FF, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{BEQ,  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[6]  = '{BNE,  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{BLT,  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{BGEU, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{3'b010, 32'h5, 32'h7, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[10] = '{3'b011, 32'h7, 32'h7, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[11] = '{BGE,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};

    i_reset    = 1'b1;
    i_flush    = 1'b0;
    i_valid    = 1'b0;
    i_ready    = 1'b1;
    i_rs1_data = '0;
    i_rs2_data = '0;
    i_funct3   = '0;
    i_tag      = '0;
    cur_res    = '0;
    cur_lat    = 1'b0;

    // reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_outs",
        {o_br_less, o_br_equal, o_taken, o_illegal, o_tag}, 64'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    // back-to-back vectors, 2-cycle latency checked
    for (int i = 0; i < 12; i++) send(vt[i], TW'(i), 1'b1);
    drain();

    // backpressure: consumer stalled from the start
    i_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(vt[i], TW'(i), 1'b0);
      end
      begin
        repeat (4) @(negedge i_clk);
        chk("bp_ready_low", 64'(o_ready), 64'd0);
        repeat (3) @(negedge i_clk);
        chk("bp_ready_still_low", 64'(o_ready), 64'd0);
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();

    // flush with two in flight and a new input presented
    send(vt[5], 6'd10, 1'b1);
    send(vt[6], 6'd11, 1'b1);
    present(vt[0], 6'd12, 1'b1);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    @(negedge i_clk);
    chk("flush_v1", 64'(o_valid), 64'd0);
    @(negedge i_clk);
    chk("flush_v2", 64'(o_valid), 64'd0);
    @(posedge i_clk);
    #1;
    send(vt[7], 6'd13, 1'b1);
    drain();

    // asynchronous reset mid-stream
    send(vt[0], 6'd30, 1'b1);
    send(vt[1], 6'd31, 1'b1);
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("arst_valid", 64'(o_valid), 64'd0);
    q.delete();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("arst_outs",
        {o_br_less, o_br_equal, o_taken, o_illegal, o_tag}, 64'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    send(vt[4], 6'd33, 1'b1);
    drain();

`ifdef BRC_PERF_EN
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk("perf_eval_rst", 64'(o_eval_cnt), 64'd0);
    for (int i = 0; i < 10; i++) send(vt[pl[i]], TW'(i), 1'b1);
    drain();
    chk("perf_eval", 64'(o_eval_cnt), 64'd10);
    chk("perf_taken", 64'(o_taken_cnt), 64'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/brc_pipe.md
Name: brc_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle branch comparator.
- Takes two operands plus RISC-V branch funct3 and produces less/equal flags plus a resolved taken bit for all six branch types.
- Two register stages with valid/ready flow control and a flush input, for the pipelined core's EX stage where a 32-bit compare no longer meets timing.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, segment width for the stage-1 partial compares; NCHUNK = WIDTH/CHUNK, which must be >= 1.
- TAG_W, 6, width of the opaque sideband tag carried with each operation.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_flush  in  1  kill all in-flight operations.
- i_valid  in  1  input operation valid.
- o_ready  out  1  block can accept an input this cycle.
- i_rs1_data  in  WIDTH  operand A.
- i_rs2_data  in  WIDTH  operand B.
- i_funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- i_tag  in  TAG_W  sideband, returned unchanged.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_br_less  out  1  rs1 < rs2 under the mode selected by funct3[1] (1 = unsigned).
- o_br_equal  out  1  rs1 == rs2.
- o_taken  out  1  branch condition is true.
- o_illegal  out  1  funct3 is 010 or 011.
- o_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (asynchronous, active-high):
  - Stage valids s1_v and s2_v clear to 0.
  - All outputs reset to 0.
  - Data registers also reset to 0; no X-propagation is allowed.
- Pipeline flow:
  - s2_adv = !s2_v | i_ready.
  - s1_adv = !s1_v | s2_adv.
  - o_ready = s1_adv, combinational from i_ready; no ready-to-ready loop exists upstream.
  - Input handshake fires when i_valid & o_ready.
  - Output handshake fires when o_valid & i_ready.
  - o_valid = s2_v.
- Stage 1 (registered on input handshake):
  - Per chunk k, latch eq[k] = (a_k == b_k) and ltu[k] = (a_k < b_k), both unsigned.
  - Also latch sign bits a[WIDTH-1] and b[WIDTH-1], funct3, and tag.
- Stage 2 (registered when s1_adv and s1_v):
  - equal = &eq.
  - ult = MSB-first priority: the ltu of the highest chunk whose eq is 0; 0 if all chunks are equal.
  - slt = (sa ^ sb) ? sa : ult.
  - less = funct3[1] ? ult : slt.
  - taken: BEQ equal; BNE !equal; BLT/BLTU less; BGE/BGEU !less.
  - illegal = (funct3[2:1] == 01); when illegal, taken = 0 while less and equal are still reported.
- Latency and throughput:
  - Latency is exactly 2 cycles from input handshake to o_valid, with no backpressure.
  - Throughput is 1 operation per cycle.
- Backpressure:
  - While o_valid & !i_ready, all stage-2 outputs hold stable.
  - Stage 1 holds if it is occupied.
  - o_ready drops only when both stages are full and i_ready = 0.
- Flush:
  - i_flush = 1 clears s1_v and s2_v at the next edge.
  - An input presented in the same cycle is dropped even if o_ready = 1.
  - An output handshake in the flush cycle still counts as delivered.
  - Data registers need not clear.
- NCHUNK == 1 degenerates to a single whole-word compare; latency is unchanged.
- Reset asserted mid-operation discards all in-flight results; o_valid = 0 immediately, asynchronously.

Optional Feature:
- Macro: BRC_PERF_EN.
- When defined, adds ports o_eval_cnt (out, 32) and o_taken_cnt (out, 32).
  - o_eval_cnt increments on each output handshake.
  - o_taken_cnt increments on each output handshake with o_taken = 1.
  - Both wrap at 2^32, reset to 0, and are unaffected by flush of undelivered entries.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package brc_pkg holds:
  - Enum typedef br_funct3_e with BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - Constant F3_UNSIGNED_BIT = 1.
  - Function is_illegal_f3().
- One sub-module is natural: brc_chunk_cmp (CHUNK-wide eq/ltu compare), instantiated NCHUNK times via generate.

Test Plan:
- BLTU rs1=0x0000_0001, rs2=0xFFFF_FFFF, i_ready=1 -> 2 cycles later o_valid=1, less=1, equal=0, taken=1.
- BLT with the same operands -> less=0, taken=0. BGE rs1=rs2=0x8000_0000 -> equal=1, less=0, taken=1.
- Chunk priority: BLTU rs1=0x0100_00FF, rs2=0x00FF_FF00 -> less=0, taken=0 (the higher chunk decides). Swap the operands -> taken=1.
- Backpressure: stream 4 ops with i_ready=0 from cycle 2 -> o_ready=0 after 2 accepted, outputs stable. Release i_ready -> results in order with tags 0,1,2,3 and none lost.
- Flush: 2 ops in flight plus an input presented with i_flush=1 -> no o_valid afterwards, and the next op returns with correct tag and 2-cycle latency.
- funct3=010 -> o_illegal=1, taken=0. Assert i_reset mid-stream -> o_valid=0 at once. With BRC_PERF_EN, 10 ops with 3 taken -> o_eval_cnt=10, o_taken_cnt=3.
